// File: rtl/univ_shifter_pkg.sv
// Shared definitions for the universal shifter: mode codes, FSM encoding and
// the default shift-amount width helper.
package univ_shifter_pkg;

    localparam logic [2:0] MODE_SLL = 3'd0;
    localparam logic [2:0] MODE_SRL = 3'd1;
    localparam logic [2:0] MODE_SRA = 3'd2;
    localparam logic [2:0] MODE_ROL = 3'd3;
    localparam logic [2:0] MODE_ROR = 3'd4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int unsigned default_amt_w(input int unsigned width);
        return int'($clog2(width)) + 1;
    endfunction

endpackage

// File: rtl/univ_shifter_step.sv
// Combinational shift/rotate of a word by sh positions in one of five modes;
// reserved modes pass the word through unchanged.
module univ_shifter_step
    import univ_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = default_amt_w(WIDTH)
) (
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] sh,
    output logic [WIDTH-1:0] result
);

    logic [AMT_W-1:0]        rot;
    logic signed [WIDTH-1:0] sra;

    always_comb begin
        // Rotates wrap modulo WIDTH; plain shifts saturate naturally for sh >= WIDTH.
        rot    = AMT_W'(32'(sh) % WIDTH);
        sra    = $signed(in) >>> sh;
        result = in;
        case (mode)
            MODE_SLL: result = in << sh;
            MODE_SRL: result = in >> sh;
            MODE_SRA: result = sra;
            MODE_ROL: result = (in << rot) | (in >> (32'(WIDTH) - 32'(rot)));
            MODE_ROR: result = (in >> rot) | (in << (32'(WIDTH) - 32'(rot)));
            default:  result = in;
        endcase
    end

endmodule

// File: rtl/univ_shifter.sv
// Loadable WIDTH-bit shift engine with start/busy/done handshake; define
// UNIV_SHIFTER_BARREL_EN for a single-cycle barrel shift instead of iterated steps.
module univ_shifter
    import univ_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = default_amt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] out_nx;
    logic [WIDTH-1:0] step_res;
    logic             busy_nx;
    logic             done_nx;

`ifdef UNIV_SHIFTER_BARREL_EN
    univ_shifter_step #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_step (
        .in     (out),
        .mode   (mode),
        .sh     (amt),
        .result (step_res)
    );
`else
    logic [AMT_W-1:0] cnt;
    logic [AMT_W-1:0] cnt_nx;
    logic [2:0]       mode_q;
    logic [2:0]       mode_nx;

    univ_shifter_step #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_step (
        .in     (out),
        .mode   (mode_q),
        .sh     (AMT_W'(1)),
        .result (step_res)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
`ifdef UNIV_SHIFTER_BARREL_EN
        state_nx = ST_IDLE;
`else
        if (load) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start && (amt != '0)) state_nx = ST_SHIFT;
                ST_SHIFT: if (cnt == AMT_W'(1))     state_nx = ST_IDLE;
                default:  state_nx = ST_IDLE;
            endcase
        end
`endif
    end

    // Next values of the registered outputs; load always wins.
    always_comb begin
        out_nx  = out;
        busy_nx = busy;
        done_nx = 1'b0;
`ifndef UNIV_SHIFTER_BARREL_EN
        cnt_nx  = cnt;
        mode_nx = mode_q;
`endif
        if (load) begin
            out_nx  = data;
            busy_nx = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
`ifdef UNIV_SHIFTER_BARREL_EN
                        out_nx  = step_res;
                        done_nx = 1'b1;
`else
                        mode_nx = mode;
                        if (amt == '0) begin
                            done_nx = 1'b1;
                        end else begin
                            busy_nx = 1'b1;
                            cnt_nx  = amt;
                        end
`endif
                    end
                end
                ST_SHIFT: begin
`ifndef UNIV_SHIFTER_BARREL_EN
                    out_nx = step_res;
                    cnt_nx = cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        done_nx = 1'b1;
                        busy_nx = 1'b0;
                    end
`endif
                end
                default: begin
                    busy_nx = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
`ifndef UNIV_SHIFTER_BARREL_EN
            cnt    <= '0;
            mode_q <= MODE_SLL;
`endif
        end else begin
            out  <= out_nx;
            busy <= busy_nx;
            done <= done_nx;
`ifndef UNIV_SHIFTER_BARREL_EN
            cnt    <= cnt_nx;
            mode_q <= mode_nx;
`endif
        end
    end

endmodule

// File: tb/tb_univ_shifter.sv
// Randomised self-checking bench for univ_shifter (WIDTH=8) against a bit-level
// reference model; follows UNIV_SHIFTER_BARREL_EN for expected timing.
module tb_univ_shifter;

`ifdef UNIV_SHIFTER_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] data = '0;
    logic       start = 1'b0;
    logic [2:0] mode = '0;
    logic [3:0] amt = '0;
    logic [7:0] out;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    univ_shifter #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .data  (data),
        .start (start),
        .mode  (mode),
        .amt   (amt),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference: each result bit is picked from its source bit position.
    function automatic logic [7:0] model(input logic [7:0] v, input int m, input int a);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[i];
            case (m)
                0: r[i] = (i >= a) ? v[(i - a) & 7] : 1'b0;
                1: r[i] = (i + a < 8) ? v[(i + a) & 7] : 1'b0;
                2: r[i] = (i + a < 8) ? v[(i + a) & 7] : v[7];
                3: r[i] = v[(i - (a % 8) + 8) % 8];
                4: r[i] = v[(i + a) % 8];
                default: r[i] = v[i];
            endcase
        end
        return r;
    endfunction

    function automatic int exp_done_edge(input int a);
        return (BARREL || a == 0) ? 1 : 1 + a;
    endfunction

    function automatic int exp_busy(input int a);
        return (BARREL || a == 0) ? 0 : a;
    endfunction

    task automatic do_load(input logic [7:0] d);
        @(negedge clk);
        load = 1'b1;
        data = d;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    // Issue one start and observe done/busy over a bounded window of edges.
    task automatic run_op(input int m, input int a, output int done_edge,
                          output int done_cnt, output int busy_cyc);
        int win;
        win = exp_done_edge(a) + 2;
        @(negedge clk);
        start = 1'b1;
        mode  = 3'(m);
        amt   = 4'(a);
        done_edge = 0;
        done_cnt  = 0;
        busy_cyc  = 0;
        for (int k = 1; k <= win; k++) begin
            @(posedge clk);
            #1 start = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_edge == 0) done_edge = k;
            end
            if (busy) busy_cyc++;
        end
    endtask

    task automatic test_reset;
        #1;
        tests++;
        if ({out, busy, done} !== 10'd0) begin
            fails++;
            $display("FAIL reset: out=%h busy=%b done=%b, want 00/0/0", out, busy, done);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_load;
        do_load(8'hAC);
        tests++;
        if (out !== 8'hAC || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL load: out=%h busy=%b done=%b, want ac/0/0", out, busy, done);
        end
    endtask

    task automatic test_directed;
        logic [7:0] vin [5]  = '{8'hAC, 8'hAC, 8'hF0, 8'h81, 8'hAC};
        int         vm  [5]  = '{0, 2, 4, 3, 1};
        int         va  [5]  = '{3, 2, 4, 9, 8};
        logic [7:0] vexp[5]  = '{8'h60, 8'hEB, 8'h0F, 8'h03, 8'h00};
        int de, dc, bc;
        for (int i = 0; i < 5; i++) begin
            do_load(vin[i]);
            run_op(vm[i], va[i], de, dc, bc);
            tests++;
            if (out !== vexp[i] || de != exp_done_edge(va[i]) || dc != 1 || bc != exp_busy(va[i])) begin
                fails++;
                $display("FAIL directed[%0d]: out=%h done_edge=%0d pulses=%0d busy=%0d, want %h/%0d/1/%0d",
                         i, out, de, dc, bc, vexp[i], exp_done_edge(va[i]), exp_busy(va[i]));
            end
        end
    endtask

    task automatic test_amt_zero;
        int de, dc, bc;
        do_load(8'h5B);
        run_op(1, 0, de, dc, bc);
        tests++;
        if (out !== 8'h5B || de != 1 || dc != 1 || bc != 0) begin
            fails++;
            $display("FAIL amt_zero: out=%h done_edge=%0d pulses=%0d busy=%0d, want 5b/1/1/0",
                     out, de, dc, bc);
        end
    endtask

    task automatic test_random;
        logic [7:0] v;
        int m, a, de, dc, bc;
        for (int i = 0; i < 40; i++) begin
            v = 8'($urandom);
            m = int'($urandom_range(0, 7));
            a = int'($urandom_range(0, 15));
            do_load(v);
            run_op(m, a, de, dc, bc);
            tests++;
            if (out !== model(v, m, a) || de != exp_done_edge(a) || dc != 1 || bc != exp_busy(a)) begin
                fails++;
                $display("FAIL random: v=%h mode=%0d amt=%0d out=%h de=%0d dc=%0d bc=%0d, want %h/%0d/1/%0d",
                         v, m, a, out, de, dc, bc, model(v, m, a), exp_done_edge(a), exp_busy(a));
            end
        end
    endtask

    task automatic test_load_start;
        int dc;
        do_load(8'h11);
        @(negedge clk);
        load = 1'b1; data = 8'h3C; start = 1'b1; mode = 3'd0; amt = 4'd2;
        @(posedge clk);
        #1 load = 1'b0; start = 1'b0;
        dc = 0;
        for (int k = 0; k < 4; k++) begin
            if (done) dc++;
            @(posedge clk); #1;
        end
        tests++;
        if (out !== 8'h3C || busy !== 1'b0 || dc != 0) begin
            fails++;
            $display("FAIL load_start: out=%h busy=%b done_pulses=%0d, want 3c/0/0", out, busy, dc);
        end
    endtask

    task automatic test_load_abort;
`ifndef UNIV_SHIFTER_BARREL_EN
        int dc;
        do_load(8'hAC);
        @(negedge clk);
        start = 1'b1; mode = 3'd1; amt = 4'd5;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        load = 1'b1; data = 8'h5A;
        @(posedge clk);
        #1 load = 1'b0;
        dc = 0;
        for (int k = 0; k < 7; k++) begin
            if (done) dc++;
            @(posedge clk); #1;
        end
        tests++;
        if (out !== 8'h5A || busy !== 1'b0 || dc != 0) begin
            fails++;
            $display("FAIL load_abort: out=%h busy=%b done_pulses=%0d, want 5a/0/0", out, busy, dc);
        end
`endif
    endtask

    task automatic test_back_to_back;
        int de, dc, bc;
        do_load(8'hC3);
`ifdef UNIV_SHIFTER_BARREL_EN
        run_op(3, 2, de, dc, bc);
        run_op(1, 1, de, dc, bc);
        tests++;
        if (out !== model(model(8'hC3, 3, 2), 1, 1) || de != 1 || dc != 1) begin
            fails++;
            $display("FAIL back_to_back: out=%h de=%0d dc=%0d, want %h/1/1",
                     out, de, dc, model(model(8'hC3, 3, 2), 1, 1));
        end
`else
        // A second start during the shift must be ignored, not queued.
        @(negedge clk);
        start = 1'b1; mode = 3'd3; amt = 4'd4;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = 3'd0; amt = 4'd1;
        @(posedge clk);
        #1 start = 1'b0;
        dc = 0; bc = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) dc++;
            if (busy) bc++;
            @(posedge clk); #1;
        end
        tests++;
        if (out !== model(8'hC3, 3, 4) || dc != 1 || bc != 3) begin
            fails++;
            $display("FAIL back_to_back: out=%h done_pulses=%0d busy_seen=%0d, want %h/1/3",
                     out, dc, bc, model(8'hC3, 3, 4));
        end
`endif
    endtask

    task automatic test_reset_mid;
        int de, dc, bc;
        do_load(8'hFF);
        @(negedge clk);
        start = 1'b1; mode = 3'd1; amt = 4'd5;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: out=%h busy=%b done=%b, want 00/0/0", out, busy, done);
        end
        @(negedge clk) rst = 1'b0;
        run_op(4, 1, de, dc, bc);
        tests++;
        if (out !== 8'h00 || de != exp_done_edge(1) || dc != 1 || bc != exp_busy(1)) begin
            fails++;
            $display("FAIL reset_restart: out=%h de=%0d dc=%0d bc=%0d, want 00/%0d/1/%0d",
                     out, de, dc, bc, exp_done_edge(1), exp_busy(1));
        end
    endtask

    initial begin
        test_reset;
        test_load;
        test_directed;
        test_amt_zero;
        test_random;
        test_load_start;
        test_load_abort;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

endmodule
